// File: rtl/alu_pipeline_nstage_pkg.sv
// alu_pipeline_nstage_pkg
//   Shared types for the ALU pipeline shell: forwarding bundle, commit
//   output record, younger-write (WAW) notification and the per-stage
//   payload carried down the pipe.
//   No ports (package).
package alu_pipeline_nstage_pkg;

  // Deepest pipeline the shared types can describe.
  localparam int NStagesMax = 4;
  // Widest result any ALU flavour produces (CHERIoT capability width).
  localparam int OpW        = 65;
  // Latency field wide enough to name any stage up to NStagesMax.
  localparam int LatWMax    = 3;

  // Younger writes issued by the issuer this cycle (two issue channels).
  typedef struct packed {
    logic [1:0] valid;
    logic [4:0] rd0;
    logic [4:0] rd1;
  } waw_act_t;

  // Per-stage forwarding view; index s-1 describes stage s, index
  // NStages-1 is WB.
  typedef struct packed {
    logic [NStagesMax-1:0]          valid;
    logic [NStagesMax-1:0][4:0]     addr;
    logic [NStagesMax-1:0][OpW-1:0] data;
  } pl_fwdn_t;

  // Record handed to commit; exception fields are unused by the ALU.
  typedef struct packed {
    logic           we;
    logic           wrsv;
    logic [4:0]     waddr;
    logic [OpW-1:0] wdata;
    logic [31:0]    pc;
    logic           err;
    logic [5:0]     mcause;
    logic [31:0]    mtval;
    logic           is_cap;
  } pl_out_t;

  // Everything a stage holds apart from its valid bit.
  typedef struct packed {
    logic [4:0]         rd;
    logic               we;
    logic [31:0]        pc;
    logic [LatWMax-1:0] lat;
    logic               have_res;
    logic               cancel;
    logic [OpW-1:0]     data;
  } alupl_stage_t;

  // True when either younger-write channel targets rd.
  function automatic logic waw_hit(input waw_act_t waw, input logic [4:0] rd);
    return (waw.valid[0] && (waw.rd0 == rd)) || (waw.valid[1] && (waw.rd1 == rd));
  endfunction

endpackage

// File: rtl/alu_pipeline_nstage_stage.sv
// alu_pipeline_nstage_stage
//   One register slice of the ALU pipeline: late-result capture, sticky
//   WAW cancel, stall detection and forward-valid generation.
// Ports:
//   clk_i, rst_ni, flush_i  clock, async active-low reset, pipeline kill
//   in_valid, in_payload    instruction offered by the previous stage
//   rdy                     this stage may load (empty or draining)
//   late_valid, late_result multi-cycle unit result for lat==StageIdx
//   waw_act                 younger writes issued this cycle
//   valid, blocked          occupancy and "waiting for late result"
//   out_valid, out_payload  what this stage hands downstream this cycle
//   fwd_valid               forward valid for the registered contents
//   fwd_valid_next,
//   fwd_addr_next           forward valid / rd the stage will hold next
//   fwd_addr, fwd_data      registered rd / result for forwarding
module alu_pipeline_nstage_stage
  import alu_pipeline_nstage_pkg::*;
#(
  parameter int StageIdx = 1,
  parameter bit FwdEn    = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           in_valid,
  input  alupl_stage_t   in_payload,
  input  logic           rdy,
  input  logic           late_valid,
  input  logic [OpW-1:0] late_result,
  input  waw_act_t       waw_act,
  output logic           valid,
  output logic           blocked,
  output logic           out_valid,
  output alupl_stage_t   out_payload,
  output logic           fwd_valid,
  output logic           fwd_valid_next,
  output logic [4:0]     fwd_addr_next,
  output logic [4:0]     fwd_addr,
  output logic [OpW-1:0] fwd_data
);

  localparam logic [LatWMax-1:0] MyLat = LatWMax'(StageIdx);

  logic         valid_q, valid_d;
  alupl_stage_t payload_q, payload_d;

  // Effective contents this cycle: fold in a late result arriving for this
  // stage and any younger write to our rd, so both travel with the
  // instruction if it moves on at this edge.
  always_comb begin
    out_payload = payload_q;
    if (valid_q && (payload_q.lat == MyLat) && !payload_q.have_res && late_valid) begin
      out_payload.data     = late_result;
      out_payload.have_res = 1'b1;
    end
    if (valid_q && waw_hit(waw_act, payload_q.rd)) begin
      out_payload.cancel = 1'b1;
    end
  end

  assign blocked   = valid_q && (out_payload.lat == MyLat) && !out_payload.have_res;
  assign out_valid = valid_q && !blocked;
  assign valid     = valid_q;

  // Next-state selection: flush wins over everything, otherwise load the
  // upstream instruction when allowed, otherwise hold our own contents.
  always_comb begin
    valid_d   = valid_q;
    payload_d = out_payload;
    if (flush_i) begin
      valid_d            = 1'b0;
      payload_d.have_res = 1'b0;
      payload_d.cancel   = 1'b0;
    end else if (rdy) begin
      valid_d = in_valid;
      if (in_valid) begin
        payload_d = in_payload;
      end
    end
  end

  assign fwd_valid = FwdEn && valid_q && payload_q.we && (payload_q.rd != 5'd0) &&
                     payload_q.have_res && !payload_q.cancel && !flush_i;
  assign fwd_valid_next = FwdEn && valid_d && payload_d.we && (payload_d.rd != 5'd0) &&
                          payload_d.have_res && !payload_d.cancel;
  assign fwd_addr_next  = payload_d.rd;
  assign fwd_addr       = payload_q.rd;
  assign fwd_data       = payload_q.data;

  // Stage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/alu_pipeline_nstage.sv
// alu_pipeline_nstage
//   Elastic integer/CHERI ALU pipeline shell, stages EX1..EXn with the last
//   stage acting as WB. Results become available at a per-instruction stage
//   (lat_i); stages publish forwarding info that is cancelled when a younger
//   write to the same rd is issued.
// Build option:
//   ALUPL_STAGE_FWD_EN  defined: stages 2..NStages forward;
//                       undefined: only WB forwards.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   flush_i            kill all in-flight instructions
//   us_valid_i/alupl_rdy_o  issue handshake
//   rd_i, rf_we_i, lat_i, pc_i, ex1_result_i  issued instruction
//   late_result_i, late_valid_i  multi-cycle unit result
//   waw_act_i          younger writes issued this cycle
//   fwd_act_o          registered per-register forward-pending bitmap
//   fwd_info_o         per-stage forwarding valid/addr/data
//   ds_rdy_i/alupl_valid_o/alupl_output_o  commit handshake and record
module alu_pipeline_nstage
  import alu_pipeline_nstage_pkg::*;
#(
  parameter int NStages = 3,
  parameter int DataW   = 65,
  parameter int LatW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             us_valid_i,
  output logic             alupl_rdy_o,
  input  logic [4:0]       rd_i,
  input  logic             rf_we_i,
  input  logic [LatW-1:0]  lat_i,
  input  logic [31:0]      pc_i,
  input  logic [DataW-1:0] ex1_result_i,
  input  logic [DataW-1:0] late_result_i,
  input  logic             late_valid_i,
  input  waw_act_t         waw_act_i,
  output logic [31:0]      fwd_act_o,
  output pl_fwdn_t         fwd_info_o,
  input  logic             ds_rdy_i,
  output logic             alupl_valid_o,
  output pl_out_t          alupl_output_o
);

`ifdef ALUPL_STAGE_FWD_EN
  localparam bit FwdAllStages = 1'b1;
`else
  localparam bit FwdAllStages = 1'b0;
`endif

  logic [NStages-1:0] stg_valid, stg_blocked, stg_out_valid, stg_rdy, stg_in_valid;
  logic [NStages-1:0] stg_fwd_valid, stg_fwd_valid_next;
  alupl_stage_t       stg_in_payload  [NStages];
  alupl_stage_t       stg_out_payload [NStages];
  logic [4:0]         stg_fwd_addr_next [NStages];
  logic [4:0]         stg_fwd_addr      [NStages];
  logic [OpW-1:0]     stg_fwd_data      [NStages];
  alupl_stage_t       issue_payload, wb_payload;
  logic [31:0]        fwd_act_d, fwd_act_q;

  // Build the EX1 payload from the issuer; a latency-1 op already has its
  // result in hand.
  always_comb begin
    issue_payload          = '0;
    issue_payload.rd       = rd_i;
    issue_payload.we       = rf_we_i;
    issue_payload.pc       = pc_i;
    issue_payload.lat      = LatWMax'(lat_i);
    issue_payload.have_res = (lat_i == LatW'(1));
    issue_payload.cancel   = 1'b0;
    issue_payload.data     = OpW'(ex1_result_i);
  end

  // Ready ripples from commit back to EX1; a stage waiting on its late
  // result holds itself and everything behind it.
  always_comb begin
    stg_rdy = '0;
    stg_rdy[NStages-1] = !stg_valid[NStages-1] || (ds_rdy_i && !stg_blocked[NStages-1]);
    for (int i = NStages - 2; i >= 0; i--) begin
      stg_rdy[i] = !stg_valid[i] || (stg_rdy[i+1] && !stg_blocked[i]);
    end
  end

  assign alupl_rdy_o = stg_rdy[0];

  for (genvar i = 0; i < NStages; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stg_in_valid[i]   = us_valid_i;
      assign stg_in_payload[i] = issue_payload;
    end else begin : g_body
      assign stg_in_valid[i]   = stg_out_valid[i-1];
      assign stg_in_payload[i] = stg_out_payload[i-1];
    end

    alu_pipeline_nstage_stage #(
      .StageIdx (i + 1),
      .FwdEn    (FwdAllStages ? (i >= 1) : (i == NStages - 1))
    ) u_stage (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .in_valid       (stg_in_valid[i]),
      .in_payload     (stg_in_payload[i]),
      .rdy            (stg_rdy[i]),
      .late_valid     (late_valid_i),
      .late_result    (OpW'(late_result_i)),
      .waw_act        (waw_act_i),
      .valid          (stg_valid[i]),
      .blocked        (stg_blocked[i]),
      .out_valid      (stg_out_valid[i]),
      .out_payload    (stg_out_payload[i]),
      .fwd_valid      (stg_fwd_valid[i]),
      .fwd_valid_next (stg_fwd_valid_next[i]),
      .fwd_addr_next  (stg_fwd_addr_next[i]),
      .fwd_addr       (stg_fwd_addr[i]),
      .fwd_data       (stg_fwd_data[i])
    );
  end

  // Gather the per-stage forwarding view; unused upper slots stay zero.
  always_comb begin
    fwd_info_o = '0;
    for (int i = 0; i < NStages; i++) begin
      fwd_info_o.valid[i] = stg_fwd_valid[i];
      fwd_info_o.addr[i]  = stg_fwd_addr[i];
      fwd_info_o.data[i]  = stg_fwd_data[i];
    end
  end

  // Decode what will be forwardable after this edge into a register map;
  // x0 is never pending.
  always_comb begin
    fwd_act_d = '0;
    for (int i = 0; i < NStages; i++) begin
      if (stg_fwd_valid_next[i]) begin
        fwd_act_d[stg_fwd_addr_next[i]] = 1'b1;
      end
    end
    fwd_act_d[0] = 1'b0;
  end

  // Registered forward-pending bitmap, cleared by flush on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_act_q <= '0;
    end else if (flush_i) begin
      fwd_act_q <= '0;
    end else begin
      fwd_act_q <= fwd_act_d;
    end
  end

  assign fwd_act_o = fwd_act_q;

  assign wb_payload    = stg_out_payload[NStages-1];
  assign alupl_valid_o = stg_out_valid[NStages-1];

  // Commit record; a cancelled write still reports we but not wrsv.
  always_comb begin
    alupl_output_o       = '0;
    alupl_output_o.we    = wb_payload.we;
    alupl_output_o.wrsv  = wb_payload.we && !wb_payload.cancel;
    alupl_output_o.waddr = wb_payload.rd;
    alupl_output_o.wdata = wb_payload.data;
    alupl_output_o.pc    = wb_payload.pc;
  end

endmodule

// File: tb/tb_alu_pipeline_nstage.sv
// tb_alu_pipeline_nstage
//   Directed self-checking bench for alu_pipeline_nstage (NStages=3).
//   Expectations for intermediate-stage forwarding follow the
//   ALUPL_STAGE_FWD_EN build option.
module tb_alu_pipeline_nstage;
  import alu_pipeline_nstage_pkg::*;

  localparam int NStages = 3;
  localparam int DataW   = 65;
  localparam int LatW    = 2;

`ifdef ALUPL_STAGE_FWD_EN
  localparam bit FwdAll = 1'b1;
`else
  localparam bit FwdAll = 1'b0;
`endif

  logic             clk_i;
  logic             rst_ni;
  logic             flush_i;
  logic             us_valid_i;
  logic             alupl_rdy_o;
  logic [4:0]       rd_i;
  logic             rf_we_i;
  logic [LatW-1:0]  lat_i;
  logic [31:0]      pc_i;
  logic [DataW-1:0] ex1_result_i;
  logic [DataW-1:0] late_result_i;
  logic             late_valid_i;
  waw_act_t         waw_act_i;
  logic [31:0]      fwd_act_o;
  pl_fwdn_t         fwd_info_o;
  logic             ds_rdy_i;
  logic             alupl_valid_o;
  pl_out_t          alupl_output_o;

  int checks = 0;
  int errors = 0;

  alu_pipeline_nstage #(
    .NStages (NStages),
    .DataW   (DataW),
    .LatW    (LatW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .us_valid_i     (us_valid_i),
    .alupl_rdy_o    (alupl_rdy_o),
    .rd_i           (rd_i),
    .rf_we_i        (rf_we_i),
    .lat_i          (lat_i),
    .pc_i           (pc_i),
    .ex1_result_i   (ex1_result_i),
    .late_result_i  (late_result_i),
    .late_valid_i   (late_valid_i),
    .waw_act_i      (waw_act_i),
    .fwd_act_o      (fwd_act_o),
    .fwd_info_o     (fwd_info_o),
    .ds_rdy_i       (ds_rdy_i),
    .alupl_valid_o  (alupl_valid_o),
    .alupl_output_o (alupl_output_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive the issue-side inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we,
                               input logic [LatW-1:0] lat, input logic [31:0] pc,
                               input logic [DataW-1:0] res);
    us_valid_i   = v;
    rd_i         = rd;
    rf_we_i      = we;
    lat_i        = lat;
    pc_i         = pc;
    ex1_result_i = res;
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    ds_rdy_i      = 1'b1;
    late_valid_i  = 1'b0;
    late_result_i = '0;
    waw_act_i     = '0;
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, '0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", alupl_valid_o, 1'b0);
    checkOutput("rst_fwd_act", fwd_act_o, 32'h0);
    checkOutput("rst_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("rst_wdata", alupl_output_o.wdata, '0);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst_rdy", alupl_rdy_o, 1'b1);

    // Back-to-back lat=1 writes to x5, x6, x7
    applyStimulus(1'b1, 5'd5, 1'b1, 2'd1, 32'h100, 65'd100);
    checkOutput("t1_rdy", alupl_rdy_o, 1'b1);
    tick();
    checkOutput("t1_e1_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("t1_e1_fwd_act", fwd_act_o, 32'h0);
    applyStimulus(1'b1, 5'd6, 1'b1, 2'd1, 32'h104, 65'd200);
    late_valid_i  = 1'b1;
    late_result_i = 65'hBAD;
    tick();
    late_valid_i  = 1'b0;
    checkOutput("t1_e2_fwd_valid", fwd_info_o.valid, {2'b00, FwdAll, 1'b0});
    checkOutput("t1_e2_fwd_act", fwd_act_o, FwdAll ? 32'h0000_0020 : 32'h0);
    checkOutput("t1_e2_out_valid", alupl_valid_o, 1'b0);
    applyStimulus(1'b1, 5'd7, 1'b1, 2'd1, 32'h108, 65'd300);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    checkOutput("t1_x5_valid", alupl_valid_o, 1'b1);
    checkOutput("t1_x5_waddr", alupl_output_o.waddr, 5'd5);
    checkOutput("t1_x5_wdata", alupl_output_o.wdata, 65'd100);
    checkOutput("t1_x5_pc", alupl_output_o.pc, 32'h100);
    checkOutput("t1_x5_wrsv", alupl_output_o.wrsv, 1'b1);
    checkOutput("t1_e3_fwd_valid", fwd_info_o.valid, {2'b01, FwdAll, 1'b0});
    checkOutput("t1_e3_fwd_addr2", fwd_info_o.addr[2], 5'd5);
    checkOutput("t1_e3_fwd_data2", fwd_info_o.data[2], 65'd100);
    checkOutput("t1_e3_fwd_act", fwd_act_o, 32'h0000_0020 | (FwdAll ? 32'h0000_0040 : 32'h0));
    tick();
    checkOutput("t1_x6_waddr", alupl_output_o.waddr, 5'd6);
    checkOutput("t1_x6_wdata", alupl_output_o.wdata, 65'd200);
    checkOutput("t1_e4_fwd_act", fwd_act_o, 32'h0000_0040 | (FwdAll ? 32'h0000_0080 : 32'h0));
    tick();
    checkOutput("t1_x7_valid", alupl_valid_o, 1'b1);
    checkOutput("t1_x7_wdata", alupl_output_o.wdata, 65'd300);
    tick();
    checkOutput("t1_drain_valid", alupl_valid_o, 1'b0);
    checkOutput("t1_drain_fwd_act", fwd_act_o, 32'h0);

    // lat=3 op to x8 with its late result withheld, two lat=1 ops behind it
    applyStimulus(1'b1, 5'd8, 1'b1, 2'd3, 32'h200, 65'h55);
    tick();
    applyStimulus(1'b1, 5'd10, 1'b1, 2'd1, 32'h204, 65'h11);
    late_valid_i  = 1'b1;
    late_result_i = 65'hDEAD;
    tick();
    late_valid_i  = 1'b0;
    applyStimulus(1'b1, 5'd11, 1'b1, 2'd1, 32'h208, 65'h22);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    checkOutput("t2_hold_valid", alupl_valid_o, 1'b0);
    checkOutput("t2_hold_rdy", alupl_rdy_o, 1'b0);
    checkOutput("t2_hold_fwd_valid", fwd_info_o.valid, {2'b00, FwdAll, 1'b0});
    checkOutput("t2_hold_fwd_act", fwd_act_o, FwdAll ? 32'h0000_0400 : 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2_wait_valid", alupl_valid_o, 1'b0);
      checkOutput("t2_wait_rdy", alupl_rdy_o, 1'b0);
    end
    late_valid_i  = 1'b1;
    late_result_i = 65'hABC;
    #1;
    checkOutput("t2_late_valid", alupl_valid_o, 1'b1);
    checkOutput("t2_late_waddr", alupl_output_o.waddr, 5'd8);
    checkOutput("t2_late_wdata", alupl_output_o.wdata, 65'hABC);
    checkOutput("t2_late_pc", alupl_output_o.pc, 32'h200);
    checkOutput("t2_late_rdy", alupl_rdy_o, 1'b1);
    tick();
    late_valid_i = 1'b0;
    checkOutput("t2_x10_waddr", alupl_output_o.waddr, 5'd10);
    checkOutput("t2_x10_wdata", alupl_output_o.wdata, 65'h11);
    tick();
    checkOutput("t2_x11_wdata", alupl_output_o.wdata, 65'h22);
    tick();
    checkOutput("t2_drain_valid", alupl_valid_o, 1'b0);

    // Younger write to x9 while x9 sits in stage 2
    applyStimulus(1'b1, 5'd9, 1'b1, 2'd1, 32'h300, 65'h99);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    tick();
    checkOutput("t3_s2_fwd_valid", fwd_info_o.valid, {2'b00, FwdAll, 1'b0});
    waw_act_i.valid = 2'b11;
    waw_act_i.rd0   = 5'd4;
    waw_act_i.rd1   = 5'd9;
    tick();
    waw_act_i = '0;
    #1;
    checkOutput("t3_wb_valid", alupl_valid_o, 1'b1);
    checkOutput("t3_wb_we", alupl_output_o.we, 1'b1);
    checkOutput("t3_wb_wrsv", alupl_output_o.wrsv, 1'b0);
    checkOutput("t3_wb_waddr", alupl_output_o.waddr, 5'd9);
    checkOutput("t3_wb_wdata", alupl_output_o.wdata, 65'h99);
    checkOutput("t3_wb_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("t3_wb_fwd_act", fwd_act_o, 32'h0);
    tick();

    // Fill with ds_rdy_i low, then flush while the issuer still offers
    applyStimulus(1'b1, 5'd12, 1'b1, 2'd1, 32'h400, 65'h12);
    tick();
    applyStimulus(1'b1, 5'd13, 1'b1, 2'd1, 32'h404, 65'h13);
    tick();
    applyStimulus(1'b1, 5'd14, 1'b1, 2'd1, 32'h408, 65'h14);
    tick();
    ds_rdy_i = 1'b0;
    applyStimulus(1'b1, 5'd15, 1'b1, 2'd1, 32'h40C, 65'h15);
    checkOutput("t4_full_rdy", alupl_rdy_o, 1'b0);
    checkOutput("t4_full_valid", alupl_valid_o, 1'b1);
    checkOutput("t4_full_fwd_valid", fwd_info_o.valid, {2'b01, FwdAll, 1'b0});
    checkOutput("t4_full_fwd_act", fwd_act_o, 32'h0000_1000 | (FwdAll ? 32'h0000_2000 : 32'h0));
    ds_rdy_i = 1'b1;
    flush_i  = 1'b1;
    #1;
    checkOutput("t4_flush_fwd_valid", fwd_info_o.valid, 4'b0000);
    tick();
    flush_i = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    checkOutput("t4_post_fwd_act", fwd_act_o, 32'h0);
    checkOutput("t4_post_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("t4_post_rdy", alupl_rdy_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_post_valid", alupl_valid_o, 1'b0);
      tick();
    end

    // Write to x0 is never forwarded
    applyStimulus(1'b1, 5'd0, 1'b1, 2'd1, 32'h500, 65'h77);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    tick();
    checkOutput("t5_s2_fwd_valid", fwd_info_o.valid, 4'b0000);
    tick();
    checkOutput("t5_wb_valid", alupl_valid_o, 1'b1);
    checkOutput("t5_wb_we", alupl_output_o.we, 1'b1);
    checkOutput("t5_wb_waddr", alupl_output_o.waddr, 5'd0);
    checkOutput("t5_wb_wdata", alupl_output_o.wdata, 65'h77);
    checkOutput("t5_wb_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("t5_wb_fwd_act", fwd_act_o, 32'h0);
    tick();

    // lat=2 op to x20 whose result arrives while it sits in stage 2
    applyStimulus(1'b1, 5'd20, 1'b1, 2'd2, 32'h600, 65'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd1, 32'h0, '0);
    tick();
    checkOutput("t6_s2_fwd_valid", fwd_info_o.valid, 4'b0000);
    checkOutput("t6_s2_out_valid", alupl_valid_o, 1'b0);
    late_valid_i  = 1'b1;
    late_result_i = 65'h2222;
    tick();
    late_valid_i = 1'b0;
    checkOutput("t6_wb_valid", alupl_valid_o, 1'b1);
    checkOutput("t6_wb_waddr", alupl_output_o.waddr, 5'd20);
    checkOutput("t6_wb_wdata", alupl_output_o.wdata, 65'h2222);
    checkOutput("t6_wb_fwd_valid", fwd_info_o.valid, 4'b0100);
    checkOutput("t6_wb_fwd_act", fwd_act_o, 32'h0010_0000);
    tick();
    checkOutput("t6_drain_valid", alupl_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
